instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential RV64I(+Zba) instruction encoder: the producer-side counterpart of the pipeline's instruction decoder. It accepts decoded-style requests (instruction class, ALU operation code, register indices, immediate), range-checks them, and emits 32-bit instruction words with their fetch addresses through a 2-entry output buffer. It sits between the testbench/boot-loader command stream and the instruction-memory write port, so programs can be built from the same control vocabulary the decoder produces.

## Interface
- BASE_ADDR, 64'h0, address tagged on the first emitted word after reset
- DEPTH, 2, output buffer entries (power of two, ≥2)
- clk  in  1  clock, all state rising-edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_class  in  4  0 LD, 1 SD, 2 R, 3 RW, 4 I, 5 IW, 6 BEQ, 7 LUI, 8 JAL; others illegal
- in_alu  in  5  ALU op code: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 xor, 00101 sll, 00110 srl, 00111 sra, 01000 addw, 01001 subw, 01010 sllw, 01011 srlw, 01100 sraw, 10010 sh3add
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  signed immediate (byte offset for BEQ/JAL; full upper value for LUI)
- out_valid  out  1  instruction word valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_instr  out  32  encoded instruction
- out_addr  out  64  address of out_instr
- err  out  1  one-cycle pulse: a request was rejected
- err_count  out  16  saturating count of rejected requests

## Operation
- Opcodes: LD 0000011/f3 011, SD 0100011/f3 011, R 0110011, RW 0111011, I 0010011, IW 0011011, BEQ 1100011/f3 000, LUI 0110111, JAL 1101111.
- R/I f3: add/sub 000, sll 001, xor 100, or 110, and 111, srl/sra 101; sub/sra funct7 0100000 else 0000000. W forms use same f3 with add/sub/sll/srl/sra only.
- I-type sll/srl/sra: imm[11:6] = 000000 / 010000 (sra), shamt 6 bits (0..63); IW shifts funct7 0000000/0100000, shamt 0..31.
- Legality (violation → reject): class >8; ALU code not valid for class (R: 64-bit codes + sh3add; RW/IW: W codes, IW excludes subw; I excludes sub); LD/SD/I/IW imm outside −2048..2047 (non-shift); shamt out of range; BEQ imm odd or outside −4096..4094; JAL imm odd or outside −1048576..1048574; LUI in_imm[11:0] ≠ 0. LD/LUI/JAL ignore in_alu; BEQ/SD ignore in_rd; LD/I/IW/LUI/JAL ignore in_rs2.
- Rejected requests are consumed (handshake completes), never emitted, do not advance out_addr; err pulses next cycle, err_count +1 saturating at 16'hFFFF.
- Legal requests: encoded into a pipeline register, then pushed into the FIFO; out_addr = running PC, starts BASE_ADDR, +4 per output handshake, wraps modulo 2^64.

## Timing
- Reset values: in_ready 0, out_valid 0, out_instr 0, out_addr BASE_ADDR, err 0, err_count 0; FIFO emptied, PC = BASE_ADDR. in_ready rises the cycle after rst deasserts.
- Latency: accepted legal request visible on out_instr 2 cycles later (encode stage + FIFO write) when FIFO empty.
- Throughput 1 request/cycle with out_ready held high.
- in_ready = 0 when encode stage occupied and FIFO full (stage cannot drain); no combinational path out_ready → in_ready.
- out_instr/out_addr stable while out_valid && !out_ready.
- Simultaneous FIFO push and pop when full: both succeed, occupancy unchanged.
- Reset mid-stream: all in-flight words discarded, no output handshake in the reset cycle.

## Configuration
- ZBA_EN defined: in_alu 10010 with class R encodes sh3add (funct7 0010000, f3 110).
- ZBA_EN undefined: 10010 is illegal for every class → reject, err pulse.

## Test plan
- Reset, then R add rd=3 rs1=1 rs2=2, out_ready=1 → out_instr 32'h002081B3, out_addr 0, err 0.
- I sra rd=5 rs1=5 imm=63 then IW sraw imm=31 → 32'h43F2D293 then 32'h41F2D29B at addresses 0, 4.
- BEQ rs1=1 rs2=2 imm=−8 → 32'hFE208CE3; same with imm=7 → rejected, err pulse, err_count 1, PC unchanged.
- out_ready=0 for 10 cycles, stream 5 legal requests → in_ready falls after 3 accepts; outputs resume in order with addresses 0,4,8,12,16, no loss or duplication.
- R sh3add rd=10 rs1=11 rs2=12: with ZBA_EN → 32'h20C5E533; without → rejected, err_count increments.
- LUI imm=32'h12345000 rd=1 → 32'h123450B7; rst asserted while FIFO holds 2 words → out_valid 0 next cycle, out_addr BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV64I(+Zba) instruction encoder with encode stage and output FIFO.
// Optional feature macro: ZBA_EN (R-class sh3add encoding).
module instr_encoder #(
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int unsigned DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_class,
    input  logic [4:0]  in_alu,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_addr,
    output logic        err,
    output logic [15:0] err_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic        ready_en_q, ready_en_d;
    logic        stage_valid_q, stage_valid_d;
    logic [31:0] stage_instr_q, stage_instr_d;
    logic [31:0] mem_q [DEPTH];
    logic [31:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0] pc_q, pc_d;
    logic        err_q, err_d;
    logic [15:0] err_count_q, err_count_d;

    logic signed [31:0] simm;
    logic        imm12_ok, shamt6_ok, shamt5_ok;
    logic [2:0]  f3;
    logic        alt, sh, alu_r, alu_w, alu_zba, zba_bad;
    logic        legal;
    logic [31:0] enc;
    logic        fifo_full, pop, push, accept;

    assign simm      = $signed(in_imm);
    assign imm12_ok  = (simm >= -32'sd2048) && (simm <= 32'sd2047);
    assign shamt6_ok = (in_imm[31:6] == 26'd0);
    assign shamt5_ok = (in_imm[31:5] == 27'd0);

    // ALU code to funct3 / alternate-funct7 and the class families it belongs to
    always_comb begin
        f3      = 3'b000;
        alt     = 1'b0;
        sh      = 1'b0;
        alu_r   = 1'b0;
        alu_w   = 1'b0;
        alu_zba = 1'b0;
        case (in_alu)
            5'b00000: alu_r = 1'b1;
            5'b00001: begin alu_r = 1'b1; alt = 1'b1; end
            5'b00010: begin alu_r = 1'b1; f3 = 3'b111; end
            5'b00011: begin alu_r = 1'b1; f3 = 3'b110; end
            5'b00100: begin alu_r = 1'b1; f3 = 3'b100; end
            5'b00101: begin alu_r = 1'b1; f3 = 3'b001; sh = 1'b1; end
            5'b00110: begin alu_r = 1'b1; f3 = 3'b101; sh = 1'b1; end
            5'b00111: begin alu_r = 1'b1; f3 = 3'b101; sh = 1'b1; alt = 1'b1; end
            5'b01000: alu_w = 1'b1;
            5'b01001: begin alu_w = 1'b1; alt = 1'b1; end
            5'b01010: begin alu_w = 1'b1; f3 = 3'b001; sh = 1'b1; end
            5'b01011: begin alu_w = 1'b1; f3 = 3'b101; sh = 1'b1; end
            5'b01100: begin alu_w = 1'b1; f3 = 3'b101; sh = 1'b1; alt = 1'b1; end
`ifdef ZBA_EN
            5'b10010: begin alu_zba = 1'b1; f3 = 3'b110; end
`endif
            default: ;
        endcase
    end

`ifdef ZBA_EN
    assign zba_bad = 1'b0;
`else
    assign zba_bad = (in_alu == 5'b10010);
`endif

    always_comb begin
        legal = 1'b0;
        enc   = 32'h0;
        case (in_class)
            4'd0: begin
                legal = imm12_ok;
                enc   = {in_imm[11:0], in_rs1, 3'b011, in_rd, 7'b0000011};
            end
            4'd1: begin
                legal = imm12_ok;
                enc   = {in_imm[11:5], in_rs2, in_rs1, 3'b011, in_imm[4:0], 7'b0100011};
            end
            4'd2: begin
                legal = alu_r || alu_zba;
                enc   = {(alu_zba ? 7'b0010000 : {1'b0, alt, 5'b00000}), in_rs2, in_rs1, f3, in_rd, 7'b0110011};
            end
            4'd3: begin
                legal = alu_w;
                enc   = {1'b0, alt, 5'b00000, in_rs2, in_rs1, f3, in_rd, 7'b0111011};
            end
            4'd4: begin
                legal = alu_r && (in_alu != 5'b00001) && (sh ? shamt6_ok : imm12_ok);
                enc   = {(sh ? {1'b0, alt, 4'b0000, in_imm[5:0]} : in_imm[11:0]), in_rs1, f3, in_rd, 7'b0010011};
            end
            4'd5: begin
                legal = alu_w && (in_alu != 5'b01001) && (sh ? shamt5_ok : imm12_ok);
                enc   = {(sh ? {1'b0, alt, 5'b00000, in_imm[4:0]} : in_imm[11:0]), in_rs1, f3, in_rd, 7'b0011011};
            end
            4'd6: begin
                legal = !in_imm[0] && (simm >= -32'sd4096) && (simm <= 32'sd4094);
                enc   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000, in_imm[4:1], in_imm[11], 7'b1100011};
            end
            4'd7: begin
                legal = (in_imm[11:0] == 12'h000);
                enc   = {in_imm[31:12], in_rd, 7'b0110111};
            end
            4'd8: begin
                legal = !in_imm[0] && (simm >= -32'sd1048576) && (simm <= 32'sd1048574);
                enc   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
            end
            default: ;
        endcase
        if (zba_bad) begin
            legal = 1'b0;
        end
    end

    // in_ready uses only registered occupancy so out_ready never reaches it combinationally
    assign fifo_full = (count_q == FULL);
    assign out_valid = (count_q != '0) && !rst;
    assign pop       = out_valid && out_ready;
    assign push      = stage_valid_q && (!fifo_full || pop);
    assign in_ready  = ready_en_q && !rst && !(stage_valid_q && fifo_full);
    assign accept    = in_valid && in_ready;

    assign out_instr = out_valid ? mem_q[rd_ptr_q] : 32'h0;
    assign out_addr  = pc_q;
    assign err       = err_q;
    assign err_count = err_count_q;

    always_comb begin
        ready_en_d    = 1'b1;
        stage_valid_d = stage_valid_q;
        stage_instr_d = stage_instr_q;
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        pc_d          = pc_q;
        err_d         = accept && !legal;
        err_count_d   = err_count_q;

        if (push) begin
            stage_valid_d   = 1'b0;
            mem_d[wr_ptr_q] = stage_instr_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (accept && legal) begin
            stage_valid_d = 1'b1;
            stage_instr_d = enc;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            pc_d     = pc_q + 64'd4;
        end
        count_d = count_q + CW'(push) - CW'(pop);
        if (err_d && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en_q    <= 1'b0;
            stage_valid_q <= 1'b0;
            stage_instr_q <= 32'h0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 32'h0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            pc_q          <= BASE_ADDR;
            err_q         <= 1'b0;
            err_count_q   <= 16'h0;
        end else begin
            ready_en_q    <= ready_en_d;
            stage_valid_q <= stage_valid_d;
            stage_instr_q <= stage_instr_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            pc_q          <= pc_d;
            err_q         <= err_d;
            err_count_q   <= err_count_d;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized self-checking bench for instr_encoder against a field-level reference encoder.
module tb_instr_encoder;
    localparam logic [63:0] BASE = 64'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_class = '0;
    logic [4:0]  in_alu = '0, in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [63:0] out_addr;
    logic        err;
    logic [15:0] err_count;

    instr_encoder #(.BASE_ADDR(BASE), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_alu(in_alu),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference encoder: legality from integer ranges, word assembled from field values
    function automatic bit ref_encode(input int cls, input int alu, input int rd, input int rs1,
                                      input int rs2, input logic [31:0] imm_bits, output logic [31:0] w);
        int imm;
        int f3_tab [13] = '{0, 0, 7, 6, 4, 1, 5, 5, 0, 0, 1, 5, 5};
        bit alt, shift, zba;
        int f3, f12;
        imm   = $signed(imm_bits);
        alt   = alu inside {1, 7, 9, 12};
        shift = alu inside {5, 6, 7, 10, 11, 12};
        zba   = 1'b0;
`ifdef ZBA_EN
        zba   = 1'b1;
`endif
        w = 32'h0;
        if (!zba && alu == 18) return 1'b0;
        f3 = (alu == 18) ? 6 : (alu <= 12 ? f3_tab[alu] : 0);
        case (cls)
            0: begin
                if (imm < -2048 || imm > 2047) return 1'b0;
                w = ((imm & 4095) << 20) | (rs1 << 15) | (3 << 12) | (rd << 7) | 'h03;
            end
            1: begin
                if (imm < -2048 || imm > 2047) return 1'b0;
                w = (((imm >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (3 << 12) | ((imm & 31) << 7) | 'h23;
            end
            2: begin
                if (!(alu <= 7 || (zba && alu == 18))) return 1'b0;
                w = ((alt ? 32 : (alu == 18 ? 16 : 0)) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33;
            end
            3: begin
                if (alu < 8 || alu > 12) return 1'b0;
                w = ((alt ? 32 : 0) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h3B;
            end
            4, 5: begin
                if (cls == 4 && !(alu <= 7 && alu != 1)) return 1'b0;
                if (cls == 5 && !(alu inside {8, 10, 11, 12})) return 1'b0;
                if (shift) begin
                    if (imm < 0 || imm > (cls == 4 ? 63 : 31)) return 1'b0;
                    f12 = (alt ? 1024 : 0) + imm;
                end else begin
                    if (imm < -2048 || imm > 2047) return 1'b0;
                    f12 = imm & 4095;
                end
                w = (f12 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | (cls == 4 ? 'h13 : 'h1B);
            end
            6: begin
                if ((imm % 2) != 0 || imm < -4096 || imm > 4094) return 1'b0;
                f12 = imm & 'h1FFF;
                w = (((f12 >> 12) & 1) << 31) | (((f12 >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
                    | (((f12 >> 1) & 15) << 8) | (((f12 >> 11) & 1) << 7) | 'h63;
            end
            7: begin
                if ((imm & 4095) != 0) return 1'b0;
                w = (imm_bits & 32'hFFFFF000) | (rd << 7) | 'h37;
            end
            8: begin
                if ((imm % 2) != 0 || imm < -1048576 || imm > 1048574) return 1'b0;
                f12 = imm & 'h1FFFFF;
                w = (((f12 >> 20) & 1) << 31) | (((f12 >> 1) & 1023) << 21) | (((f12 >> 11) & 1) << 20)
                    | (((f12 >> 12) & 255) << 12) | (rd << 7) | 'h6F;
            end
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    logic [31:0] exp_q [$];
    logic [31:0] seen_q [$];
    logic [63:0] seen_addr [$];
    logic [63:0] model_pc = BASE;
    int          model_errs = 0;
    bit          err_next = 1'b0;
    int          acc_count = 0;
    bit          hold_valid = 1'b0;
    logic [31:0] hold_instr;
    logic [63:0] hold_addr;
    logic [31:0] mw;
    bit          mlegal;

    // Scoreboard: sampled on the falling edge, one half cycle clear of the active edge
    always @(negedge clk) begin
        if (rst) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_in_ready", in_ready, 0);
            exp_q.delete();
            model_pc   = BASE;
            model_errs = 0;
            err_next   = 1'b0;
            hold_valid = 1'b0;
        end else begin
            check("err_pulse", err, err_next);
            check("err_count", err_count, model_errs);
            if (hold_valid) begin
                check("stall_valid", out_valid, 1);
                check("stall_instr", out_instr, hold_instr);
                check("stall_addr", out_addr, hold_addr);
            end
            hold_valid = out_valid && !out_ready;
            hold_instr = out_instr;
            hold_addr  = out_addr;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    check("out_instr", out_instr, exp_q.pop_front());
                    check("out_addr", out_addr, model_pc);
                end
                seen_q.push_back(out_instr);
                seen_addr.push_back(out_addr);
                model_pc = model_pc + 64'd4;
            end
            err_next = 1'b0;
            if (in_valid && in_ready) begin
                acc_count++;
                mlegal = ref_encode(in_class, in_alu, in_rd, in_rs1, in_rs2, in_imm, mw);
                if (mlegal) exp_q.push_back(mw);
                else begin
                    err_next = 1'b1;
                    model_errs++;
                end
            end
        end
    end

    task automatic send(input int c, input int a, input int d, input int s1, input int s2, input logic [31:0] im);
        int t;
        in_valid = 1'b1;
        in_class = 4'(c);
        in_alu   = 5'(a);
        in_rd    = 5'(d);
        in_rs1   = 5'(s1);
        in_rs2   = 5'(s2);
        in_imm   = im;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 300) begin
                check("accept_timeout", 1, 0);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        seen_q.delete();
        seen_addr.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    bit done;
    logic [31:0] rimm;
    int rc, ra;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_addr", out_addr, BASE);
        check("reset_out_instr", out_instr, 0);
        check("reset_err_count", err_count, 0);
        check("reset_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        check("in_ready_rises", in_ready, 1);
        out_ready = 1'b1;

        send(2, 0, 3, 1, 2, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        check("latency_stage", out_valid, 0);
        @(negedge clk);
        check("latency_out_valid", out_valid, 1);
        check("r_add_word", out_instr, 32'h002081B3);
        check("r_add_addr", out_addr, 64'h0);
        check("r_add_err", err, 0);
        idle(3);

        do_reset();
        send(4, 7, 5, 5, 0, 32'd63);
        send(5, 12, 5, 5, 0, 32'd31);
        idle(5);
        check("shift_count", seen_q.size(), 2);
        if (seen_q.size() == 2) begin
            check("i_sra_word", seen_q[0], 32'h43F2D293);
            check("iw_sraw_word", seen_q[1], 32'h41F2D29B);
            check("shift_addr0", seen_addr[0], 64'd0);
            check("shift_addr1", seen_addr[1], 64'd4);
        end

        do_reset();
        send(6, 0, 0, 1, 2, -32'sd8);
        send(6, 0, 0, 1, 2, 32'd7);
        in_valid = 1'b0;
        @(negedge clk);
        check("beq_odd_err", err, 1);
        idle(4);
        check("beq_err_count", err_count, 1);
        check("beq_emitted", seen_q.size(), 1);
        if (seen_q.size() == 1) check("beq_word", seen_q[0], 32'hFE208CE3);
        check("beq_pc_held", out_addr, 64'd4);

        do_reset();
        out_ready = 1'b0;
        acc_count = 0;
        fork
            begin
                for (int i = 0; i < 5; i++) send(2, 0, i + 1, 1, 2, 32'd0);
                in_valid = 1'b0;
            end
            begin
                repeat (10) @(posedge clk);
                #1;
                check("bp_accepts", acc_count, 3);
                check("bp_in_ready", in_ready, 0);
                out_ready = 1'b1;
            end
        join
        idle(8);
        check("bp_count", seen_q.size(), 5);
        for (int i = 0; i < seen_q.size() && i < 5; i++) begin
            check("bp_addr", seen_addr[i], BASE + 64'(i * 4));
            check("bp_rd", seen_q[i][11:7], 5'(i + 1));
        end

        do_reset();
        send(2, 18, 10, 11, 12, 32'd0);
        idle(5);
`ifdef ZBA_EN
        check("sh3add_emitted", seen_q.size(), 1);
        if (seen_q.size() == 1) check("sh3add_word", seen_q[0], 32'h20C5E533);
`else
        check("sh3add_rejected", seen_q.size(), 0);
        check("sh3add_err_count", err_count, 1);
`endif

        do_reset();
        send(7, 0, 1, 0, 0, 32'h12345000);
        idle(4);
        check("lui_count", seen_q.size(), 1);
        if (seen_q.size() == 1) check("lui_word", seen_q[0], 32'h123450B7);

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(4, 0, i, 1, 0, 32'(i));
        idle(2);
        check("pre_rst_full", out_valid, 1);
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_cycle_no_valid", out_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen_q.delete();
        @(negedge clk);
        check("post_rst_valid", out_valid, 0);
        check("post_rst_addr", out_addr, BASE);
        idle(5);
        check("post_rst_flushed", seen_q.size(), 0);

        do_reset();
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < 400; n++) begin
                    rc = $urandom_range(0, 9);
                    if (rc == 9) rc = $urandom_range(9, 15);
                    ra = $urandom_range(0, 12);
                    if (rc >= 2 && rc <= 5 && $urandom_range(0, 7) == 0) ra = $urandom_range(0, 31);
                    case ($urandom_range(0, 3))
                        0: rimm = 32'(int'($urandom_range(0, 4200)) - 2100);
                        1: rimm = 32'(int'($urandom_range(0, 70)) - 3);
                        2: rimm = $urandom;
                        default: rimm = 32'(int'($urandom_range(0, 2100000)) - 1050000);
                    endcase
                    if ((rc == 6 || rc == 8) && $urandom_range(0, 3) != 0) rimm[0] = 1'b0;
                    if (rc == 7 && $urandom_range(0, 3) != 0) rimm[11:0] = 12'h0;
                    send(rc, ra, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), rimm);
                    if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("random_drained", exp_q.size(), 0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
